calc_input_ctrl: RTL and testbench
==================================

Name: calc_input_ctrl

Overview:
Front-end controller that drives the calculator's operand, operation and counter inputs from raw board switches and push-buttons. Synchronizes and debounces the buttons, turns a button press into a one-hot operation code, and captures both operands on that same edge. Operands and op code change together, and only on a press event. Also provides the free-running 16-bit counter consumed by the calculator's counter/display mode.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before a debounced button changes level (5 ms at 50 MHz); minimum 1.
TICK_DIV, 50000000, clock cycles per counter increment; minimum 1.

Ports:
clk_pi  input  1  system clock, rising edge
rst_n_pi  input  1  reset, asynchronous, active-low
sw_pi  input  8  raw switches; [7:4] operand1, [3:0] operand2
btn_pi  input  4  raw push-buttons, active-high; btn_pi[i] selects op 1<<i
data1_po  output  4  captured operand1
data2_po  output  4  captured operand2
op_po  output  4  operation code: 0000 concat, 0001 add, 0010 sub, 0100 mul, 1000 signed add
op_valid_po  output  1  one-cycle pulse on the edge op_po/data*_po are updated
counter_po  output  16  free-running tick counter

Behaviour:
- Reset (rst_n_pi low, asynchronous): data1_po=0, data2_po=0, op_po=0000, op_valid_po=0, counter_po=0. Synchronizers, debounce counters and debounced levels all clear to 0. Reset mid-debounce or mid-tick discards the partial count. Release is synchronous to clk_pi.
- Synchronizers: 2-flop synchronizer on every btn_pi and sw_pi bit. Switches are synchronized only, not debounced.
- Debounce, per button: counter is compared against the debounced level.
  - Synced level == debounced level: counter <= 0.
  - Synced level differs: counter increments. When the counter reaches DEBOUNCE_CYCLES-1 and the level still differs, the debounced level takes the synced level on the next edge and the counter clears.
  - Any glitch back to the debounced level restarts the count.
- Press event: debounced rising edge (registered previous value). Releases generate no event.
- Timing: btn_pi[i] goes high before edge k and is held. Debounced[i] rises at edge k+1+DEBOUNCE_CYCLES. op_po, data1_po, data2_po and op_valid_po update at edge k+2+DEBOUNCE_CYCLES. op_valid_po is high for exactly that cycle.
- Op update on a press event for button i:
  - If op_po already equals 1<<i: op_po <= 0000 (toggle back to concat).
  - Otherwise: op_po <= 1<<i.
- Simultaneous press events in one cycle: lowest index wins; the other events are dropped. The losing button must be released and re-pressed to register.
- Operand capture: on every press event, data1_po <= synced sw[7:4] and data2_po <= synced sw[3:0]. Switch changes without a press event never alter the outputs.
- op_po only ever holds 0000 or a single one-hot bit.
- Counter: prescaler counts 0..TICK_DIV-1. counter_po increments on the cycle the prescaler wraps, and wraps FFFF->0000 without flag. With TICK_DIV=1 it increments every cycle.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package calc_pkg:
  - op encodings OP_CONCAT=4'b0000, OP_ADD=4'b0001, OP_SUB=4'b0010, OP_MUL=4'b0100, OP_SADD=4'b1000
  - OPERAND_W=4, RESULT_W=8, COUNTER_W=16
- One sub-module, btn_debounce, instantiated 4x:
  - ports: clk, rst_n, raw bit, debounced level, rise pulse
  - parameter: DEBOUNCE_CYCLES
  - contains the synchronizer, debounce counter and edge detect

Test Plan:
(bench uses DEBOUNCE_CYCLES=4, TICK_DIV=1)
1. Reset: run 20 cycles, then drop rst_n_pi between clock edges -> all outputs 0 immediately, before the next edge; counter restarts from 0 after release.
2. Clean press: sw_pi=8'h3A, btn_pi[1] high before edge k and held -> at edge k+6 op_po=0010, data1_po=3, data2_po=A, op_valid_po high one cycle only; no further event while held or on release.
3. Bounce: btn_pi[2] high 3 cycles, low 1, high 2, then low -> op_po, data*_po unchanged, op_valid_po never asserts.
4. Simultaneous: btn_pi[0] and btn_pi[3] rise on the same edge with sw_pi=8'h7F -> op_po=0001, data1_po=7, data2_po=F, single op_valid_po pulse.
5. Toggle and capture: with op_po=0100, change sw_pi to 8'hC5 with no press -> outputs unchanged. Then press btn_pi[2] -> op_po=0000, data1_po=C, data2_po=5.
6. Counter wrap: 65536 cycles after reset release -> counter_po returns to 0000 after FFFF; with TICK_DIV=3 it increments every third cycle.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared widths and operation encodings for the calculator
//               input front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam int OPERAND_W = 4;
    localparam int RESULT_W  = 8;
    localparam int COUNTER_W = 16;

    typedef logic [OPERAND_W-1:0] operand_t;
    typedef logic [3:0]           op_t;

    localparam op_t OP_CONCAT = 4'b0000;
    localparam op_t OP_ADD    = 4'b0001;
    localparam op_t OP_SUB    = 4'b0010;
    localparam op_t OP_MUL    = 4'b0100;
    localparam op_t OP_SADD   = 4'b1000;

    // Lowest-index press wins; pressing the active op again returns to concat.
    function automatic op_t op_select(input logic [3:0] rise, input op_t cur);
        op_t sel;
        sel = OP_CONCAT;
        for (int i = 3; i >= 0; i--) begin
            if (rise[i]) begin
                sel    = OP_CONCAT;
                sel[i] = 1'b1;
            end
        end
        return (sel == cur) ? OP_CONCAT : sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchronizer, stability-count debouncer and rising
//               edge detector for one push-button.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             prev_q;

    // Count only while the synchronized input disagrees with the held level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/calc_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : calc_input_ctrl
// Description : Calculator front-end: debounced op buttons, operand capture
//               on press, and a prescaled free-running counter.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_input_ctrl
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TICK_DIV        = 50000000
) (
    input  logic        clk_pi,
    input  logic        rst_n_pi,
    input  logic [7:0]  sw_pi,
    input  logic [3:0]  btn_pi,
    output logic [3:0]  data1_po,
    output logic [3:0]  data2_po,
    output logic [3:0]  op_po,
    output logic        op_valid_po,
    output logic [15:0] counter_po
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [7:0]           sw_meta_q;
    logic [7:0]           sw_sync_q;
    logic [3:0]           btn_level;
    logic [3:0]           btn_rise;
    operand_t             data1_q;
    operand_t             data2_q;
    op_t                  op_q;
    logic                 valid_q;
    logic [PRESC_W-1:0]   presc_q;
    logic [COUNTER_W-1:0] count_q;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_btn_debounce (
                .clk_i  (clk_pi),
                .rst_n_i(rst_n_pi),
                .raw_i  (btn_pi[i]),
                .level_o(btn_level[i]),
                .rise_o (btn_rise[i])
            );
        end
    endgenerate

    // Operands and op code move together, only on a debounced press.
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            data1_q   <= '0;
            data2_q   <= '0;
            op_q      <= OP_CONCAT;
            valid_q   <= 1'b0;
        end else begin
            sw_meta_q <= sw_pi;
            sw_sync_q <= sw_meta_q;
            valid_q   <= |btn_rise;
            if (|btn_rise) begin
                data1_q <= sw_sync_q[7:4];
                data2_q <= sw_sync_q[3:0];
                op_q    <= op_select(btn_rise, op_q);
            end
        end
    end

    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            presc_q <= '0;
            count_q <= '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
            count_q <= count_q + 1'b1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    assign data1_po    = data1_q;
    assign data2_po    = data2_q;
    assign op_po       = op_q;
    assign op_valid_po = valid_q;
    assign counter_po  = count_q;

    // Level outputs are kept for debug visibility only.
    logic w_unused;
    assign w_unused = ^btn_level;

endmodule
`default_nettype wire

// File: tb/tb_calc_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_input_ctrl
// Description : Self-checking bench for calc_input_ctrl against a sample-
//               window reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_input_ctrl;

    localparam int D = 4;

    logic        clk_pi   = 1'b0;
    logic        rst_n_pi = 1'b0;
    logic [7:0]  sw_pi    = 8'h00;
    logic [3:0]  btn_pi   = 4'h0;

    logic [3:0]  data1_a, data2_a, op_a, data1_b, data2_b, op_b;
    logic        valid_a, valid_b;
    logic [15:0] cnt_a, cnt_b;

    calc_input_ctrl #(.DEBOUNCE_CYCLES(D), .TICK_DIV(1)) dut (
        .clk_pi(clk_pi), .rst_n_pi(rst_n_pi), .sw_pi(sw_pi), .btn_pi(btn_pi),
        .data1_po(data1_a), .data2_po(data2_a), .op_po(op_a),
        .op_valid_po(valid_a), .counter_po(cnt_a)
    );

    calc_input_ctrl #(.DEBOUNCE_CYCLES(D), .TICK_DIV(3)) dut3 (
        .clk_pi(clk_pi), .rst_n_pi(rst_n_pi), .sw_pi(sw_pi), .btn_pi(btn_pi),
        .data1_po(data1_b), .data2_po(data2_b), .op_po(op_b),
        .op_valid_po(valid_b), .counter_po(cnt_b)
    );

    always #5 clk_pi = ~clk_pi;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: histories of sampled inputs, newest first.
    logic [3:0]  bh [0:D];
    logic [7:0]  sh [0:1];
    logic [3:0]  m_deb, m_pend, m_op, m_d1, m_d2;
    logic        m_valid;
    int unsigned ticks;
    int          edge_n, vcount, last_pulse;

    task automatic model_clear();
        for (int j = 0; j <= D; j++) bh[j] = 4'h0;
        sh[0] = 8'h00; sh[1] = 8'h00;
        m_deb = 4'h0; m_pend = 4'h0; m_op = 4'h0; m_d1 = 4'h0; m_d2 = 4'h0;
        m_valid = 1'b0; ticks = 0;
    endtask

    task automatic model_update();
        logic [3:0] nd;
        logic       all_diff;
        int         win;
        nd = m_deb;
        // A level flips once the D samples reaching the debouncer all disagree.
        for (int b = 0; b < 4; b++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= D; j++) if (bh[j][b] == m_deb[b]) all_diff = 1'b0;
            if (all_diff) nd[b] = ~m_deb[b];
        end
        m_valid = 1'b0;
        if (m_pend != 4'h0) begin
            win = 0;
            for (int i = 3; i >= 0; i--) if (m_pend[i]) win = i;
            m_op    = (m_op == (4'h1 << win)) ? 4'h0 : (4'h1 << win);
            m_d1    = sh[1][7:4];
            m_d2    = sh[1][3:0];
            m_valid = 1'b1;
        end
        m_pend = nd & ~m_deb;
        m_deb  = nd;
        for (int j = D; j >= 1; j--) bh[j] = bh[j-1];
        bh[0] = btn_pi;
        sh[1] = sh[0];
        sh[0] = sw_pi;
        ticks++;
    endtask

    task automatic compare();
        check("op",     op_a,    m_op);
        check("data1",  data1_a, m_d1);
        check("data2",  data2_a, m_d2);
        check("valid",  valid_a, m_valid);
        check("cnt",    cnt_a,   ticks % 65536);
        check("op3",    op_b,    m_op);
        check("valid3", valid_b, m_valid);
        check("cnt3",   cnt_b,   (ticks / 3) % 65536);
    endtask

    task automatic step(input logic [7:0] s, input logic [3:0] b);
        sw_pi  = s;
        btn_pi = b;
        @(posedge clk_pi);
        edge_n++;
        model_update();
        #1;
        compare();
        if (valid_a) begin
            vcount++;
            last_pulse = edge_n;
        end
        @(negedge clk_pi);
    endtask

    task automatic hold(input logic [7:0] s, input logic [3:0] b, input int n);
        for (int i = 0; i < n; i++) step(s, b);
    endtask

    task automatic do_reset();
        @(posedge clk_pi);
        #2 rst_n_pi = 1'b0;
        #1;
        check("rst_op",    op_a,    4'h0);
        check("rst_data1", data1_a, 4'h0);
        check("rst_data2", data2_a, 4'h0);
        check("rst_valid", valid_a, 1'b0);
        check("rst_cnt",   cnt_a,   16'h0);
        check("rst_cnt3",  cnt_b,   16'h0);
        model_clear();
        @(negedge clk_pi);
        rst_n_pi = 1'b1;
    endtask

    initial begin
        int k, v0, n;
        logic [7:0] s;
        logic [3:0] b;
        edge_n = 0; vcount = 0; last_pulse = 0;
        model_clear();
        repeat (3) @(negedge clk_pi);
        rst_n_pi = 1'b1;

        // 1: reset mid-run, counter restarts from zero
        hold(8'h00, 4'h0, 20);
        do_reset();
        step(8'h00, 4'h0);
        check("t1_cnt", cnt_a, 16'h1);

        // 2: clean press of button 1
        v0 = vcount;
        hold(8'h3A, 4'b0010, 1);
        k = edge_n;
        hold(8'h3A, 4'b0010, 9);
        hold(8'h3A, 4'b0000, 10);
        check("t2_op",     op_a,        4'b0010);
        check("t2_data1",  data1_a,     4'h3);
        check("t2_data2",  data2_a,     4'hA);
        check("t2_edge",   last_pulse,  k + 6);
        check("t2_pulses", vcount - v0, 1);

        // 3: bounce never long enough to register
        v0 = vcount;
        hold(8'h3A, 4'b0100, 3);
        hold(8'h3A, 4'b0000, 1);
        hold(8'h3A, 4'b0100, 2);
        hold(8'h3A, 4'b0000, 10);
        check("t3_op",     op_a,        4'b0010);
        check("t3_pulses", vcount - v0, 0);

        // 4: simultaneous press, lowest index wins
        v0 = vcount;
        hold(8'h7F, 4'b1001, 10);
        hold(8'h7F, 4'b0000, 10);
        check("t4_op",     op_a,        4'b0001);
        check("t4_data1",  data1_a,     4'h7);
        check("t4_data2",  data2_a,     4'hF);
        check("t4_pulses", vcount - v0, 1);

        // 5: switches alone change nothing; re-press toggles to concat
        hold(8'h7F, 4'b0100, 10);
        hold(8'h7F, 4'b0000, 10);
        check("t5_op_mul", op_a, 4'b0100);
        hold(8'hC5, 4'b0000, 10);
        check("t5_hold_op", op_a,    4'b0100);
        check("t5_hold_d1", data1_a, 4'h7);
        check("t5_hold_d2", data2_a, 4'hF);
        hold(8'hC5, 4'b0100, 10);
        hold(8'hC5, 4'b0000, 10);
        check("t5_op",    op_a,    4'b0000);
        check("t5_data1", data1_a, 4'hC);
        check("t5_data2", data2_a, 4'h5);

        // Randomized runs of button/switch patterns, with a reset in the middle
        for (int r = 0; r < 400; r++) begin
            s = 8'($urandom);
            b = 4'($urandom);
            n = $urandom_range(1, 9);
            hold(s, b, n);
            if (r == 200) do_reset();
        end

        // 6: counter wrap
        do_reset();
        for (int i = 0; i < 65536; i++) step(8'($urandom), 4'h0);
        check("t6_wrap",  cnt_a, 16'h0000);
        check("t6_cnt3",  cnt_b, 16'h5555);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
